// File: rtl/ssd_scan_scheduler.sv
// Four-digit multiplexed seven-segment scan scheduler with blanking dead time,
// double-buffered frame data and leading-zero suppression.
module ssd_scan_scheduler #(
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        lz_en,
   input  logic        load_valid,
   input  logic [19:0] load_data,
   output logic        load_ready,
   output logic [3:0]  anode,
   output logic [6:0]  segOut,
   output logic        frame_done
);

   localparam int unsigned MaxCyc = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int unsigned CntW   = (MaxCyc > 2) ? $clog2(MaxCyc) : 1;
   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
   localparam logic [19:0]     AllBlank  = {4{5'd16}};

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

   state_e          state_q, state_d;
   logic [1:0]      d_q, d_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [19:0]     active_q, active_d;
   logic [19:0]     pend_q, pend_d;
   logic            pend_valid_q, pend_valid_d;
   logic [3:0]      anode_d;
   logic [6:0]      seg_d;
   logic            frame_done_d;
   logic            boundary;
   logic            xfer;
   logic [4:0]      code [4];
   logic [3:0]      sup;

   function automatic logic [6:0] seg_decode(input logic [4:0] c);
      logic [6:0] s;
      case (c)
         5'd0:    s = 7'b1000000;
         5'd1:    s = 7'b1111001;
         5'd2:    s = 7'b0100100;
         5'd3:    s = 7'b0110000;
         5'd4:    s = 7'b0011001;
         5'd5:    s = 7'b0010010;
         5'd6:    s = 7'b0000010;
         5'd7:    s = 7'b1111000;
         5'd8:    s = 7'b0000000;
         5'd9:    s = 7'b0010000;
         5'd10:   s = 7'b0001000;
         5'd11:   s = 7'b0000011;
         5'd12:   s = 7'b1000110;
         5'd13:   s = 7'b0100001;
         5'd14:   s = 7'b0000110;
         5'd15:   s = 7'b0001110;
         5'd17:   s = 7'b0111111;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Scan sequencing; boundary marks the DRIVE d=3 -> BLANK d=0 transition.
   always_comb begin
      state_d  = state_q;
      d_d      = d_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (!en) begin
         state_d = StIdle;
         d_d     = 2'd0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StBlank;
               d_d     = 2'd0;
               cnt_d   = '0;
            end
            StBlank: begin
               if (cnt_q == BlankLast) begin
                  state_d = StDrive;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StDrive: begin
               if (cnt_q == DwellLast) begin
                  state_d  = StBlank;
                  cnt_d    = '0;
                  d_d      = d_q + 2'd1;
                  boundary = (d_q == 2'd3);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Transfer needs a full pending buffer and a load needs an empty one, so both never coincide.
   always_comb begin
      xfer         = pend_valid_q && (boundary || (state_q == StIdle));
      active_d     = xfer ? pend_q : active_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (xfer) begin
         pend_valid_d = 1'b0;
      end else if (load_valid && !pend_valid_q) begin
         pend_d       = load_data;
         pend_valid_d = 1'b1;
      end
   end

   // Outputs are computed from next-state values so they update on the same edge as the state.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         code[k] = active_d[5*k +: 5];
      end
      sup[3] = lz_en && (code[3] == 5'd0);
      sup[2] = sup[3] && (code[2] == 5'd0);
      sup[1] = sup[2] && (code[1] == 5'd0);
      sup[0] = 1'b0;

      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
      if (state_d != StIdle) begin
         seg_d = sup[d_d] ? 7'b1111111 : seg_decode(code[d_d]);
      end
      if (state_d == StDrive) begin
         anode_d = ~(4'b0001 << d_d);
      end
      frame_done_d = (state_d == StDrive) && (d_d == 2'd3) && (cnt_d == DwellLast);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         d_q          <= 2'd0;
         cnt_q        <= '0;
         active_q     <= AllBlank;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         anode        <= 4'b1111;
         segOut       <= 7'b1111111;
         frame_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         d_q          <= d_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         anode        <= anode_d;
         segOut       <= seg_d;
         frame_done   <= frame_done_d;
      end
   end

   assign load_ready = !pend_valid_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Scoreboard bench for ssd_scan_scheduler with BLANK_CYCLES=2, DWELL_CYCLES=4 (24-cycle frame).
module tb_ssd_scan_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        lz_en = 1'b0;
   logic        load_valid = 1'b0;
   logic [19:0] load_data = '0;
   logic        load_ready;
   logic [3:0]  anode;
   logic [6:0]  segOut;
   logic        frame_done;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       fd;
      logic       lr;
   } exp_t;

   exp_t sb[$];

   localparam logic [19:0] Blanks = {4{5'd16}};

   ssd_scan_scheduler #(
      .DWELL_CYCLES(4),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .lz_en     (lz_en),
      .load_valid(load_valid),
      .load_data (load_data),
      .load_ready(load_ready),
      .anode     (anode),
      .segOut    (segOut),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [6:0] dec(input logic [4:0] c);
      case (c)
         5'd0: return 7'b1000000;   5'd1: return 7'b1111001;
         5'd2: return 7'b0100100;   5'd3: return 7'b0110000;
         5'd4: return 7'b0011001;   5'd5: return 7'b0010010;
         5'd6: return 7'b0000010;   5'd7: return 7'b1111000;
         5'd8: return 7'b0000000;   5'd9: return 7'b0010000;
         5'd10: return 7'b0001000;  5'd11: return 7'b0000011;
         5'd12: return 7'b1000110;  5'd13: return 7'b0100001;
         5'd14: return 7'b0000110;  5'd15: return 7'b0001110;
         5'd17: return 7'b0111111;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] digit_seg(input logic [19:0] codes, input bit lz, input int k);
      bit zeros = 1'b1;
      for (int j = k; j < 4; j++) begin
         if (codes[j*5 +: 5] != 5'd0) zeros = 1'b0;
      end
      if (lz && k > 0 && zeros) return 7'b1111111;
      return dec(codes[k*5 +: 5]);
   endfunction

   // Pushes the first n cycles of a frame; load_ready expected high for cycle index <= fall.
   task automatic push_frame(input logic [19:0] codes, input bit lz, input int fall, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         int dg;
         int ph;
         dg     = i / 6;
         ph     = i % 6;
         e.an   = (ph < 2) ? 4'b1111 : ~(4'b0001 << dg);
         e.seg  = digit_seg(codes, lz, dg);
         e.fd   = (i == 23);
         e.lr   = (i <= fall);
         sb.push_back(e);
      end
   endtask

   task automatic push_idle(input logic lr);
      exp_t e;
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.fd  = 1'b0;
      e.lr  = lr;
      sb.push_back(e);
   endtask

   // Checks n cycles against the scoreboard; optionally offers load data from index ld_idx.
   task automatic run_check(input int n, input int ld_idx, input int ld_len, input logic [19:0] ld);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: cycle %0d had no expected entry", i);
         end else begin
            e = sb.pop_front();
            if ({anode, segOut, frame_done, load_ready} !== e) begin
               n_bad++;
               $display("FAIL scan cycle %0d: got an=%b seg=%b fd=%b lr=%b want an=%b seg=%b fd=%b lr=%b",
                        i, anode, segOut, frame_done, load_ready, e.an, e.seg, e.fd, e.lr);
            end
         end
         if (i == ld_idx) begin
            load_valid = 1'b1;
            load_data  = ld;
         end else if (i == ld_idx + ld_len || i == 0) begin
            load_valid = 1'b0;
         end
      end
   endtask

   // Loads a frame while idle: pending fills on one edge, is applied on the next.
   task automatic load_idle(input logic [19:0] codes);
      load_valid = 1'b1;
      load_data  = codes;
      push_idle(1'b0);
      push_idle(1'b1);
      run_check(2, -1, 1, '0);
   endtask

   task automatic stop_scan(input logic lr);
      en = 1'b0;
      push_idle(lr);
      run_check(1, -1, 1, '0);
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if ({anode, segOut, frame_done, load_ready} !== {4'b1111, 7'b1111111, 1'b0, 1'b1}) begin
         n_bad++;
         $display("FAIL %s: got an=%b seg=%b fd=%b lr=%b want an=1111 seg=1111111 fd=0 lr=1",
                  tag, anode, segOut, frame_done, load_ready);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      en    = 1'b1;
      push_frame(Blanks, 1'b0, 23, 24);
      run_check(24, -1, 1, '0);
      stop_scan(1'b1);
   endtask

   task automatic test_scan();
      logic [19:0] c;
      c = {5'd1, 5'd2, 5'd3, 5'd4};
      load_idle(c);
      en = 1'b1;
      push_frame(c, 1'b0, 23, 24);
      push_frame(c, 1'b0, 23, 24);
      run_check(48, -1, 1, '0);
      stop_scan(1'b1);
   endtask

   task automatic test_lz();
      logic [19:0] c;
      c = {5'd0, 5'd0, 5'd7, 5'd0};
      lz_en = 1'b1;
      load_idle(c);
      en = 1'b1;
      push_frame(c, 1'b1, 23, 24);
      run_check(24, -1, 1, '0);
      stop_scan(1'b1);
      lz_en = 1'b0;
      en    = 1'b1;
      push_frame(c, 1'b0, 23, 24);
      run_check(24, -1, 1, '0);
      stop_scan(1'b1);
   endtask

   task automatic test_midframe_load();
      logic [19:0] a;
      logic [19:0] b;
      a = {5'd9, 5'd10, 5'd11, 5'd12};
      b = {5'd13, 5'd14, 5'd15, 5'd5};
      load_idle(a);
      en = 1'b1;
      push_frame(a, 1'b0, 7, 24);
      push_frame(b, 1'b0, 23, 24);
      run_check(48, 7, 1, b);
   endtask

   // Runs on directly from test_midframe_load with b active and the scan still going.
   task automatic test_back_to_back();
      logic [19:0] b;
      logic [19:0] c;
      logic [19:0] d;
      b = {5'd13, 5'd14, 5'd15, 5'd5};
      c = {5'd6, 5'd8, 5'd0, 5'd1};
      d = {5'd2, 5'd2, 5'd2, 5'd2};
      push_frame(b, 1'b0, 23, 24);
      run_check(24, 23, 1, c);
      push_frame(b, 1'b0, -1, 24);
      push_frame(c, 1'b0, 23, 24);
      run_check(48, 5, 6, d);
      stop_scan(1'b1);
   endtask

   task automatic test_en_drop();
      logic [19:0] b;
      logic [19:0] e;
      b = {5'd3, 5'd1, 5'd4, 5'd1};
      e = {5'd5, 5'd9, 5'd2, 5'd6};
      load_idle(b);
      en = 1'b1;
      push_frame(b, 1'b0, 3, 15);
      run_check(15, 3, 1, e);
      en = 1'b0;
      push_idle(1'b0);
      push_idle(1'b1);
      run_check(2, -1, 1, '0);
      en = 1'b1;
      push_frame(e, 1'b0, 23, 24);
      run_check(24, -1, 1, '0);
      stop_scan(1'b1);
   endtask

   task automatic test_async_reset();
      logic [19:0] c;
      c = {5'd17, 5'd25, 5'd17, 5'd25};
      load_idle(c);
      en = 1'b1;
      push_frame(c, 1'b0, 23, 24);
      push_frame(c, 1'b0, 23, 8);
      run_check(32, -1, 1, '0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      push_frame(Blanks, 1'b0, 23, 24);
      run_check(24, -1, 1, '0);
      stop_scan(1'b1);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_lz();
      test_midframe_load();
      test_back_to_back();
      test_en_drop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
